// File: rtl/param_study_engine_pkg.sv
// Shared constants for the study engine: FSM state codes, tempo codes and the
// "never played" score value.
package param_study_engine_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StSelect = 2'b01,
    StStudy  = 2'b10,
    StStore  = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    SpeedSlow = 2'b00,
    SpeedNorm = 2'b01,
    SpeedFast = 2'b10,
    SpeedAlt  = 2'b11
  } speed_e;

  localparam int unsigned MaxErrW = 32;

  // All-ones score of the given width marks an account that never stored a run.
  function automatic logic [MaxErrW-1:0] never_played(input int unsigned err_w);
    return (err_w >= MaxErrW) ? '1 : ((MaxErrW'(1) << err_w) - MaxErrW'(1));
  endfunction

endpackage

// File: rtl/study_tick_gen.sv
// Tempo divider: emits a one-cycle tick every DIV_* clock cycles for the
// selected speed; restart zeroes the phase.
module study_tick_gen
  import param_study_engine_pkg::*;
#(
  parameter int unsigned DIV_SLOW = 100_000_000,
  parameter int unsigned DIV_NORM = 50_000_000,
  parameter int unsigned DIV_FAST = 25_000_000
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   restart,
  input  speed_e speed,
  output logic   tick
);

  localparam int unsigned DivMax01 = (DIV_SLOW > DIV_NORM) ? DIV_SLOW : DIV_NORM;
  localparam int unsigned DivMax   = (DivMax01 > DIV_FAST) ? DivMax01 : DIV_FAST;
  localparam int unsigned CntW     = (DivMax > 1) ? $clog2(DivMax) : 1;

  localparam logic [CntW-1:0] LastSlow = CntW'(DIV_SLOW - 1);
  localparam logic [CntW-1:0] LastNorm = CntW'(DIV_NORM - 1);
  localparam logic [CntW-1:0] LastFast = CntW'(DIV_FAST - 1);

  logic [CntW-1:0] cnt_q, cnt_d, last;

  always_comb begin
    unique case (speed)
      SpeedSlow: last = LastSlow;
      SpeedFast: last = LastFast;
      default:   last = LastNorm;
    endcase
  end

  assign tick = (cnt_q == last);

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (restart || tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/param_study_engine.sv
// Guided-practice engine: walks a score ROM lighting the expected key, counts
// player errors per run and keeps a best (lowest) score per account.
module param_study_engine
  import param_study_engine_pkg::*;
#(
  parameter int unsigned NUM_KEYS      = 7,
  parameter int unsigned SONG_LEN      = 42,
  parameter int unsigned NUM_USERS     = 3,
  parameter int unsigned ERR_W         = 5,
  parameter int unsigned DIV_SLOW      = 100_000_000,
  parameter int unsigned DIV_NORM      = 50_000_000,
  parameter int unsigned DIV_FAST      = 25_000_000,
  parameter int unsigned TIMEOUT_TICKS = 4,
  parameter int unsigned STORE_TICKS   = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        abort,
  input  logic [NUM_KEYS-1:0]         key_in,
  input  logic [2:0]                  user_sel,
  input  logic                        store_req,
  input  logic [1:0]                  speed_mode,
  output logic [$clog2(SONG_LEN)-1:0] rom_addr,
  input  logic [2:0]                  rom_note,
  output logic [NUM_KEYS-1:0]         led,
  output logic [ERR_W-1:0]            err_cnt,
  output logic [ERR_W-1:0]            record,
  output logic [1:0]                  state_o,
  output logic                        done
);

  localparam int unsigned AddrW = $clog2(SONG_LEN);
  localparam int unsigned UserW = (NUM_USERS > 1) ? $clog2(NUM_USERS) : 1;
  localparam int unsigned TmoW  = $clog2(TIMEOUT_TICKS + 1);
  localparam int unsigned StoW  = $clog2(STORE_TICKS + 1);

  localparam logic [ERR_W-1:0] NeverPlayed = ERR_W'(never_played(ERR_W));
  localparam logic [AddrW-1:0] LastIdx     = AddrW'(SONG_LEN - 1);
  localparam logic [TmoW-1:0]  LastTmo     = TmoW'(TIMEOUT_TICKS - 1);
  localparam logic [StoW-1:0]  LastSto     = StoW'(STORE_TICKS - 1);

  state_e               state_q, state_d;
  speed_e               speed_q, speed_d;
  logic [AddrW-1:0]     idx_q, idx_d;
  logic [UserW-1:0]     uidx_q, uidx_d;
  logic [NUM_KEYS-1:0]  led_q, led_d;
  logic [ERR_W-1:0]     err_q, err_d;
  logic [ERR_W-1:0]     record_q, record_d;
  logic [TmoW-1:0]      tmo_q, tmo_d;
  logic [StoW-1:0]      sto_q, sto_d;
  logic                 done_q, done_d;
  logic                 rom_vld_q, rom_vld_d;
  logic                 pend_q, pend_d;
  logic [ERR_W-1:0]     score_q [NUM_USERS];
  logic [ERR_W-1:0]     score_d [NUM_USERS];

  logic                 tick, restart, eval, hit, advance, sel_ok;
  logic [NUM_KEYS-1:0]  note_oh;
  logic [UserW-1:0]     sel_idx;
  logic [ERR_W-1:0]     err_inc;

  study_tick_gen #(
    .DIV_SLOW (DIV_SLOW),
    .DIV_NORM (DIV_NORM),
    .DIV_FAST (DIV_FAST)
  ) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .speed   (speed_q),
    .tick    (tick)
  );

  always_comb begin
    state_d   = state_q;
    speed_d   = speed_q;
    idx_d     = idx_q;
    uidx_d    = uidx_q;
    led_d     = led_q;
    err_d     = err_q;
    record_d  = record_q;
    tmo_d     = tmo_q;
    sto_d     = sto_q;
    done_d    = 1'b0;
    rom_vld_d = 1'b1;
    pend_d    = pend_q;
    score_d   = score_q;
    advance   = 1'b0;

    note_oh = '0;
    if (rom_note != 3'd0) note_oh = NUM_KEYS'(1) << (rom_note - 3'd1);
    hit     = |(key_in & note_oh);
    sel_ok  = (user_sel != 3'd0) && (32'(user_sel) <= NUM_USERS);
    sel_idx = UserW'(user_sel - 3'd1);
    err_inc = (err_q == '1) ? err_q : err_q + ERR_W'(1);
    // The synchronous ROM needs one cycle after each address change; a tick
    // landing in that gap is held until the note is valid.
    eval    = (tick || pend_q) && rom_vld_q;

    unique case (state_q)
      StIdle: begin
        if (user_sel == 3'd0) state_d = StSelect;
      end
      StSelect: begin
        if (sel_ok) begin
          uidx_d    = sel_idx;
          record_d  = score_q[sel_idx];
          led_d     = '0;
          speed_d   = speed_e'(speed_mode);
          rom_vld_d = 1'b0;
          state_d   = StStudy;
        end
      end
      StStudy: begin
        if (tick && !rom_vld_q) pend_d = 1'b1;
        if (eval) begin
          pend_d = 1'b0;
          if (rom_note == 3'd0 || hit) begin
            advance = 1'b1;
          end else if (tmo_q == LastTmo) begin
            // Expiry takes precedence over a wrong key on the same tick.
            err_d   = err_inc;
            advance = 1'b1;
          end else begin
            led_d = note_oh;
            tmo_d = tmo_q + TmoW'(1);
            if (key_in != '0) err_d = err_inc;
          end
        end
        if (advance) begin
          led_d     = '0;
          tmo_d     = '0;
          rom_vld_d = 1'b0;
          if (idx_q == LastIdx) begin
            done_d  = 1'b1;
            state_d = StStore;
          end else begin
            idx_d = idx_q + AddrW'(1);
          end
        end
      end
      StStore: begin
        if (store_req) begin
          if (err_q < score_q[uidx_q] || score_q[uidx_q] == NeverPlayed) begin
            score_d[uidx_q] = err_q;
            record_d        = err_q;
          end
          state_d = StIdle;
        end else if (tick) begin
          if (sto_q == LastSto) state_d = StIdle;
          else                  sto_d   = sto_q + StoW'(1);
        end
      end
    endcase

    if (abort) begin
      state_d  = StIdle;
      score_d  = score_q;
      record_d = record_q;
      done_d   = 1'b0;
    end

    if (state_d == StIdle) begin
      err_d = '0;
      idx_d = '0;
      led_d = '1;
    end
    if (state_d == StStore) led_d = '1;

    restart = (state_d != state_q);
    if (restart) begin
      tmo_d  = '0;
      sto_d  = '0;
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      speed_q   <= SpeedNorm;
      idx_q     <= '0;
      uidx_q    <= '0;
      led_q     <= '1;
      err_q     <= '0;
      record_q  <= '0;
      tmo_q     <= '0;
      sto_q     <= '0;
      done_q    <= 1'b0;
      rom_vld_q <= 1'b0;
      pend_q    <= 1'b0;
      for (int i = 0; i < NUM_USERS; i++) score_q[i] <= NeverPlayed;
    end else begin
      state_q   <= state_d;
      speed_q   <= speed_d;
      idx_q     <= idx_d;
      uidx_q    <= uidx_d;
      led_q     <= led_d;
      err_q     <= err_d;
      record_q  <= record_d;
      tmo_q     <= tmo_d;
      sto_q     <= sto_d;
      done_q    <= done_d;
      rom_vld_q <= rom_vld_d;
      pend_q    <= pend_d;
      score_q   <= score_d;
    end
  end

  assign rom_addr = idx_q;
  assign led      = led_q;
  assign err_cnt  = err_q;
  assign record   = record_q;
  assign state_o  = state_q;
  assign done     = done_q;

endmodule

// File: tb/tb_param_study_engine.sv
// Directed bench for param_study_engine: 4-note score {1,2,0,3}, tick every
// 4 clocks at normal speed, 3-bit error counter.
module tb_param_study_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       abort = 1'b0;
  logic       store_req = 1'b0;
  logic [6:0] key_in = '0;
  logic [2:0] user_sel = '0;
  logic [1:0] speed_mode = 2'b01;
  logic [1:0] rom_addr;
  logic [2:0] rom_note;
  logic [6:0] led;
  logic [2:0] err_cnt;
  logic [2:0] record;
  logic [1:0] state_o;
  logic       done;

  logic [2:0] rom [4] = '{3'd1, 3'd2, 3'd0, 3'd3};

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [6:0] key;
    int         err;
    int         addr;
    int         st;
    int         led;
  } slot_t;

  slot_t tbl[$];

  param_study_engine #(
    .NUM_KEYS      (7),
    .SONG_LEN      (4),
    .NUM_USERS     (3),
    .ERR_W         (3),
    .DIV_SLOW      (6),
    .DIV_NORM      (4),
    .DIV_FAST      (2),
    .TIMEOUT_TICKS (4),
    .STORE_TICKS   (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .abort      (abort),
    .key_in     (key_in),
    .user_sel   (user_sel),
    .store_req  (store_req),
    .speed_mode (speed_mode),
    .rom_addr   (rom_addr),
    .rom_note   (rom_note),
    .led        (led),
    .err_cnt    (err_cnt),
    .record     (record),
    .state_o    (state_o),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_note <= rom[rom_addr];

  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void add(input logic [6:0] key, input int err, input int addr,
                              input int st, input int ld);
    slot_t s;
    s.key = key; s.err = err; s.addr = addr; s.st = st; s.led = ld;
    tbl.push_back(s);
  endfunction

  // From IDLE or SELECT: pick an account, then scramble speed_mode (must be ignored).
  task automatic start_run(input string tag, input logic [2:0] u, input logic [1:0] spd,
                           input int exp_rec);
    user_sel = 3'd0;
    speed_mode = spd;
    clk_n(1);
    chk({tag, " select"}, state_o, 1);
    user_sel = u;
    clk_n(1);
    user_sel = 3'd0;
    speed_mode = 2'b00;
    chk({tag, " study"}, state_o, 2);
    chk({tag, " led0"}, led, 0);
    chk({tag, " record"}, record, exp_rec);
  endtask

  // One table row per tick: drive the key, step to just after the tick edge.
  task automatic play(input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      key_in = tbl[i].key;
      clk_n(4);
      chk($sformatf("%s t%0d err", tag, i), err_cnt, tbl[i].err);
      chk($sformatf("%s t%0d state", tag, i), state_o, tbl[i].st);
      chk($sformatf("%s t%0d led", tag, i), led, tbl[i].led);
      chk($sformatf("%s t%0d done", tag, i), done, (tbl[i].st == 3) ? 1 : 0);
      if (tbl[i].st == 2) chk($sformatf("%s t%0d addr", tag, i), rom_addr, tbl[i].addr);
    end
    key_in = '0;
    tbl.delete();
  endtask

  function automatic void no_key_table();
    add(7'h00, 0, 0, 2, 7'h01); add(7'h00, 0, 0, 2, 7'h01); add(7'h00, 0, 0, 2, 7'h01);
    add(7'h00, 1, 1, 2, 7'h00);
    add(7'h00, 1, 1, 2, 7'h02); add(7'h00, 1, 1, 2, 7'h02); add(7'h00, 1, 1, 2, 7'h02);
    add(7'h00, 2, 2, 2, 7'h00);
    add(7'h00, 2, 3, 2, 7'h00);
    add(7'h00, 2, 3, 2, 7'h04); add(7'h00, 2, 3, 2, 7'h04); add(7'h00, 2, 3, 2, 7'h04);
    add(7'h00, 3, 0, 3, 7'h7f);
  endfunction

  task automatic store(input string tag, input int exp_rec);
    store_req = 1'b1;
    clk_n(1);
    store_req = 1'b0;
    chk({tag, " idle"}, state_o, 0);
    chk({tag, " record"}, record, exp_rec);
    chk({tag, " err clr"}, err_cnt, 0);
    chk({tag, " led"}, led, 7'h7f);
  endtask

  initial begin
    clk_n(3);
    chk("rst state", state_o, 0);
    chk("rst led", led, 7'h7f);
    chk("rst err", err_cnt, 0);
    chk("rst record", record, 0);
    chk("rst done", done, 0);
    chk("rst addr", rom_addr, 0);
    rst_n = 1'b1;

    // Every key right on its first tick; then let the store window lapse.
    start_run("A", 3'd1, 2'b01, 7);
    add(7'h01, 0, 1, 2, 7'h00); add(7'h02, 0, 2, 2, 7'h00);
    add(7'h00, 0, 3, 2, 7'h00); add(7'h04, 0, 0, 3, 7'h7f);
    play("A");
    clk_n(1);
    chk("A done pulse", done, 0);
    clk_n(30);
    chk("A store open", state_o, 3);
    clk_n(1);
    chk("A store lapse", state_o, 0);
    chk("A record kept", record, 7);

    // No keys: every playable note held four ticks, then stored into a fresh account.
    start_run("B", 3'd3, 2'b01, 7);
    no_key_table();
    play("B");
    store("B", 3);

    // Wrong-then-right keys; final note right on the expiring tick. Speed code 11.
    start_run("C", 3'd2, 2'b11, 7);
    add(7'h02, 1, 0, 2, 7'h01); add(7'h01, 1, 1, 2, 7'h00);
    add(7'h01, 2, 1, 2, 7'h02); add(7'h02, 2, 2, 2, 7'h00);
    add(7'h00, 2, 3, 2, 7'h00);
    add(7'h01, 3, 3, 2, 7'h04); add(7'h01, 4, 3, 2, 7'h04); add(7'h01, 5, 3, 2, 7'h04);
    add(7'h04, 5, 0, 3, 7'h7f);
    play("C");
    store("C", 5);

    // Worse run saturates at 7 and must not replace the stored 5.
    start_run("D", 3'd2, 2'b01, 5);
    add(7'h02, 1, 0, 2, 7'h01); add(7'h02, 2, 0, 2, 7'h01); add(7'h02, 3, 0, 2, 7'h01);
    add(7'h00, 4, 1, 2, 7'h00);
    add(7'h01, 5, 1, 2, 7'h02); add(7'h01, 6, 1, 2, 7'h02); add(7'h01, 7, 1, 2, 7'h02);
    add(7'h00, 7, 2, 2, 7'h00);
    add(7'h00, 7, 3, 2, 7'h00);
    add(7'h01, 7, 3, 2, 7'h04); add(7'h00, 7, 3, 2, 7'h04); add(7'h00, 7, 3, 2, 7'h04);
    add(7'h00, 7, 0, 3, 7'h7f);
    play("D");
    store("D", 5);

    // Abort together with store_req: nothing saved.
    start_run("E", 3'd2, 2'b01, 5);
    no_key_table();
    play("E");
    abort = 1'b1;
    store_req = 1'b1;
    clk_n(1);
    abort = 1'b0;
    store_req = 1'b0;
    chk("E abort idle", state_o, 0);
    chk("E abort err", err_cnt, 0);
    chk("E abort record", record, 5);

    // Score still 5, so a 3-error run now improves it.
    start_run("F", 3'd2, 2'b01, 5);
    no_key_table();
    play("F");
    store("F", 3);

    // Reset in the middle of a run, then every account is back to never-played.
    start_run("G", 3'd1, 2'b01, 7);
    add(7'h02, 1, 0, 2, 7'h01); add(7'h01, 1, 1, 2, 7'h00);
    play("G");
    clk_n(2);
    rst_n = 1'b0;
    clk_n(1);
    chk("G rst state", state_o, 0);
    chk("G rst led", led, 7'h7f);
    chk("G rst err", err_cnt, 0);
    chk("G rst record", record, 0);
    chk("G rst done", done, 0);
    chk("G rst addr", rom_addr, 0);
    rst_n = 1'b1;
    start_run("H", 3'd2, 2'b01, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
